// File: rtl/punc_control_if.sv
// punc_control_if: control bundle between the PUnC controller and datapath.
// The master side is the controller (consumes ir/nzp_true, drives strobes);
// the slave side is the datapath.
interface punc_control_if;
    // Datapath -> controller
    logic [15:0] ir;
    logic        nzp_true;

    // Controller -> datapath
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld;
    logic        ir_clr;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_r_addr_sel;
    logic [1:0]  mem_w_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel;
    logic        rf_w_wr;
    logic        rf_rp_addr_sel;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic        temp_ld;
    logic        temp_sel;
    logic        nzp_ld;
    logic        nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_first_val_sel;
    logic        halted;

    modport master (
        input  ir, nzp_true,
        output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
               mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, temp_sel,
               nzp_ld, nzp_clr, alu_sel, alu_first_val_sel, halted
    );

    modport slave (
        output ir, nzp_true,
        input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
               mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, temp_sel,
               nzp_ld, nzp_clr, alu_sel, alu_first_val_sel, halted
    );
endinterface

// File: rtl/punc_control.sv
// punc_control: fetch/decode/execute sequencer for the PUnC LC3 datapath.
// All strobes are a combinational function of state, ir and nzp_true.
// Optional feature macro: PUNC_INSTR_COUNT_EN adds a 16-bit instr_count
// output counting FETCH->DECODE transitions.
module punc_control (
    input  logic               clk,
    input  logic               rst,
    punc_control_if.master     bus
`ifdef PUNC_INSTR_COUNT_EN
    ,
    output logic [15:0]        instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode;
    logic       jsr_imm;

    assign opcode  = bus.ir[15:12];
    assign jsr_imm = bus.ir[11];

    // State register; reset from any state lands in FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: indirect/base stores and LDI take a second execute cycle.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_LDI || opcode == OP_STI || opcode == OP_STR) begin
                    state_d = S_EXEC2;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC2:  state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; reset overrides everything with the three clears.
    always_comb begin
        bus.pc_ld             = 1'b0;
        bus.pc_clr            = 1'b0;
        bus.pc_inc            = 1'b0;
        bus.pc_sel            = 2'd0;
        bus.ir_ld             = 1'b0;
        bus.ir_clr            = 1'b0;
        bus.mem_rd            = 1'b0;
        bus.mem_wr            = 1'b0;
        bus.mem_r_addr_sel    = 2'd0;
        bus.mem_w_addr_sel    = 2'd0;
        bus.rf_w_data_sel     = 2'd0;
        bus.rf_w_addr_sel     = 1'b0;
        bus.rf_w_wr           = 1'b0;
        bus.rf_rp_addr_sel    = 1'b0;
        bus.rf_rp_rd          = 1'b0;
        bus.rf_rq_rd          = 1'b0;
        bus.temp_ld           = 1'b0;
        bus.temp_sel          = 1'b0;
        bus.nzp_ld            = 1'b0;
        bus.nzp_clr           = 1'b0;
        bus.alu_sel           = 2'd0;
        bus.alu_first_val_sel = 1'b0;
        bus.halted            = 1'b0;

        if (rst) begin
            bus.pc_clr  = 1'b1;
            bus.ir_clr  = 1'b1;
            bus.nzp_clr = 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_rd         = 1'b1;
                    bus.mem_r_addr_sel = 2'd0;
                    bus.ir_ld          = 1'b1;
                    bus.pc_inc         = 1'b1;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            bus.rf_rp_addr_sel = 1'b0;
                            bus.rf_rp_rd       = 1'b1;
                            bus.rf_rq_rd       = (opcode != OP_NOT);
                            bus.alu_sel        = (opcode == OP_ADD) ? 2'd0 :
                                                 (opcode == OP_AND) ? 2'd1 : 2'd2;
                            bus.rf_w_data_sel  = 2'd0;
                            bus.rf_w_addr_sel  = 1'b0;
                            bus.rf_w_wr        = 1'b1;
                            bus.nzp_ld         = 1'b1;
                        end
                        OP_BR: begin
                            bus.pc_ld  = bus.nzp_true;
                            bus.pc_sel = 2'd0;
                        end
                        OP_JMP: begin
                            bus.rf_rp_addr_sel = 1'b0;
                            bus.rf_rp_rd       = 1'b1;
                            bus.pc_ld          = 1'b1;
                            bus.pc_sel         = 2'd2;
                        end
                        OP_JSR: begin
                            // PC already holds the return address; the old
                            // base register is read before R7 is overwritten.
                            bus.rf_w_addr_sel = 1'b1;
                            bus.rf_w_data_sel = 2'd3;
                            bus.rf_w_wr       = 1'b1;
                            bus.pc_ld         = 1'b1;
                            if (jsr_imm) begin
                                bus.pc_sel = 2'd1;
                            end else begin
                                bus.pc_sel         = 2'd2;
                                bus.rf_rp_addr_sel = 1'b0;
                                bus.rf_rp_rd       = 1'b1;
                            end
                        end
                        OP_LD, OP_LDR: begin
                            bus.mem_rd         = 1'b1;
                            bus.mem_r_addr_sel = (opcode == OP_LD) ? 2'd1 : 2'd2;
                            bus.rf_rp_addr_sel = 1'b0;
                            bus.rf_rp_rd       = (opcode == OP_LDR);
                            bus.rf_w_data_sel  = 2'd1;
                            bus.rf_w_wr        = 1'b1;
                            bus.nzp_ld         = 1'b1;
                        end
                        OP_LEA: begin
                            bus.rf_w_data_sel = 2'd2;
                            bus.rf_w_wr       = 1'b1;
                            bus.nzp_ld        = 1'b1;
                        end
                        OP_ST: begin
                            bus.rf_rp_addr_sel = 1'b1;
                            bus.rf_rp_rd       = 1'b1;
                            bus.mem_wr         = 1'b1;
                            bus.mem_w_addr_sel = 2'd0;
                        end
                        OP_STR: begin
                            // Compute base+offset into temp; the write happens next cycle.
                            bus.rf_rp_addr_sel = 1'b0;
                            bus.rf_rp_rd       = 1'b1;
                            bus.alu_sel        = 2'd3;
                            bus.temp_sel       = 1'b1;
                            bus.temp_ld        = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            // Fetch the pointer into temp.
                            bus.mem_rd         = 1'b1;
                            bus.mem_r_addr_sel = 2'd1;
                            bus.temp_sel       = 1'b0;
                            bus.temp_ld        = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC2: begin
                    if (opcode == OP_LDI) begin
                        bus.mem_rd         = 1'b1;
                        bus.mem_r_addr_sel = 2'd3;
                        bus.rf_w_data_sel  = 2'd1;
                        bus.rf_w_wr        = 1'b1;
                        bus.nzp_ld         = 1'b1;
                    end else begin
                        bus.rf_rp_addr_sel = 1'b1;
                        bus.rf_rp_rd       = 1'b1;
                        bus.mem_wr         = 1'b1;
                        bus.mem_w_addr_sel = 2'd1;
                    end
                end
                S_HALT: begin
                    bus.halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PUNC_INSTR_COUNT_EN
    logic [15:0] instr_count_q;

    // Count instructions fetched; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_q <= 16'd0;
        end else if (state_q == S_FETCH) begin
            instr_count_q <= instr_count_q + 16'd1;
        end
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_punc_control.sv
// tb_punc_control: randomized scoreboard bench for punc_control.
// Honours PUNC_INSTR_COUNT_EN when defined.
module tb_punc_control;

    logic clk = 1'b1;
    logic rst;

    always #5 clk = ~clk;

    punc_control_if bus ();

`ifdef PUNC_INSTR_COUNT_EN
    logic [15:0] instr_count;
    punc_control dut (.clk(clk), .rst(rst), .bus(bus), .instr_count(instr_count));
`else
    punc_control dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct packed {
        logic       pc_ld, pc_clr, pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld, ir_clr, mem_rd, mem_wr;
        logic [1:0] mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel;
        logic       rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
        logic       temp_ld, temp_sel, nzp_ld, nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_first_val_sel, halted;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_EXEC2 = 3, PH_HALT = 4;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cnt_m = 'x;

    function automatic ctl_t sample();
        ctl_t c;
        c = '{bus.pc_ld, bus.pc_clr, bus.pc_inc, bus.pc_sel, bus.ir_ld, bus.ir_clr,
              bus.mem_rd, bus.mem_wr, bus.mem_r_addr_sel, bus.mem_w_addr_sel,
              bus.rf_w_data_sel, bus.rf_w_addr_sel, bus.rf_w_wr, bus.rf_rp_addr_sel,
              bus.rf_rp_rd, bus.rf_rq_rd, bus.temp_ld, bus.temp_sel, bus.nzp_ld,
              bus.nzp_clr, bus.alu_sel, bus.alu_first_val_sel, bus.halted};
        return c;
    endfunction

    // Reference: the strobe table written out per instruction step.
    function automatic ctl_t model(bit r, int ph, logic [15:0] i, logic n);
        ctl_t c = '0;
        logic [3:0] op = i[15:12];
        if (r) begin
            c.pc_clr = 1; c.ir_clr = 1; c.nzp_clr = 1;
            return c;
        end
        if (ph == PH_FETCH) begin
            c.mem_rd = 1; c.ir_ld = 1; c.pc_inc = 1;
        end else if (ph == PH_HALT) begin
            c.halted = 1;
        end else if (ph == PH_EXEC) begin
            case (op)
                4'h1, 4'h5, 4'h9: begin
                    c.rf_rp_rd = 1; c.rf_rq_rd = (op != 4'h9);
                    c.alu_sel = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
                    c.rf_w_wr = 1; c.nzp_ld = 1;
                end
                4'h0: c.pc_ld = n;
                4'hC: begin c.rf_rp_rd = 1; c.pc_ld = 1; c.pc_sel = 2; end
                4'h4: begin
                    c.rf_w_addr_sel = 1; c.rf_w_data_sel = 3; c.rf_w_wr = 1; c.pc_ld = 1;
                    if (i[11]) c.pc_sel = 1;
                    else begin c.pc_sel = 2; c.rf_rp_rd = 1; end
                end
                4'h2: begin c.mem_rd = 1; c.mem_r_addr_sel = 1; c.rf_w_data_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'h6: begin c.mem_rd = 1; c.mem_r_addr_sel = 2; c.rf_rp_rd = 1; c.rf_w_data_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'hE: begin c.rf_w_data_sel = 2; c.rf_w_wr = 1; c.nzp_ld = 1; end
                4'h3: begin c.rf_rp_addr_sel = 1; c.rf_rp_rd = 1; c.mem_wr = 1; end
                4'h7: begin c.rf_rp_rd = 1; c.alu_sel = 3; c.temp_sel = 1; c.temp_ld = 1; end
                4'hA, 4'hB: begin c.mem_rd = 1; c.mem_r_addr_sel = 1; c.temp_ld = 1; end
                default: ;
            endcase
        end else if (ph == PH_EXEC2) begin
            if (op == 4'hA) begin
                c.mem_rd = 1; c.mem_r_addr_sel = 3; c.rf_w_data_sel = 1; c.rf_w_wr = 1; c.nzp_ld = 1;
            end else begin
                c.rf_rp_addr_sel = 1; c.rf_rp_rd = 1; c.mem_wr = 1; c.mem_w_addr_sel = 1;
            end
        end
        return c;
    endfunction

    // One clock of stimulus: drive inputs, queue the expected strobes, advance.
    task automatic cycle(input bit r, input int ph, input logic [15:0] i, input string tag);
        exp_t e;
        logic n;
        n = 1'($urandom);
        rst = r;
        bus.ir = i;
        bus.nzp_true = n;
        e.ctl = model(r, ph, i, n);
        e.cnt = cnt_m;
        e.tag = tag;
        exp_q.push_back(e);
        if (r) cnt_m = 16'd0;
        else if (ph == PH_FETCH) cnt_m = cnt_m + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_n(input bit r, input int ph, input logic [15:0] i, input logic n, input string tag);
        exp_t e;
        rst = r;
        bus.ir = i;
        bus.nzp_true = n;
        e.ctl = model(r, ph, i, n);
        e.cnt = cnt_m;
        e.tag = tag;
        exp_q.push_back(e);
        if (r) cnt_m = 16'd0;
        else if (ph == PH_FETCH) cnt_m = cnt_m + 16'd1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit two_exec(logic [15:0] i);
        return (i[15:12] == 4'hA || i[15:12] == 4'hB || i[15:12] == 4'h7);
    endfunction

    // Full instruction: FETCH (ir still shows stale contents), DECODE, EXEC[, EXEC2].
    task automatic instr(input logic [15:0] i, input string tag);
        $display("instr %s ir=%h", tag, i);
        cycle(0, PH_FETCH, 16'($urandom), {tag, ".fetch"});
        cycle(0, PH_DECODE, i, {tag, ".decode"});
        cycle(0, PH_EXEC, i, {tag, ".exec"});
        if (two_exec(i)) cycle(0, PH_EXEC2, i, {tag, ".exec2"});
    endtask

    // Scoreboard monitor: compare each cycle's strobes mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            ctl_t got;
            e = exp_q.pop_front();
            got = sample();
            n_cmp++;
            if (got !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl %s: got=%h want=%h", e.tag, got, e.ctl);
            end
`ifdef PUNC_INSTR_COUNT_EN
            if (!$isunknown(e.cnt)) begin
                n_cmp++;
                if (instr_count !== e.cnt) begin
                    n_bad++;
                    $display("FAIL instr_count %s: got=%h want=%h", e.tag, instr_count, e.cnt);
                end
            end
`endif
        end
    end

    initial begin
        logic [15:0] ri;
        rst = 1'b1;
        bus.ir = 16'h0;
        bus.nzp_true = 1'b0;

        // Reset held two cycles, then directed cases.
        cycle(1, PH_FETCH, 16'h0, "reset0");
        cycle(1, PH_FETCH, 16'h0, "reset1");
        instr(16'h12A3, "add");
        $display("instr brz_not_taken ir=0405");
        cycle(0, PH_FETCH, 16'h0, "brz0.fetch");
        cycle(0, PH_DECODE, 16'h0405, "brz0.decode");
        cycle_n(0, PH_EXEC, 16'h0405, 1'b0, "brz0.exec");
        $display("instr brz_taken ir=0405");
        cycle(0, PH_FETCH, 16'h0, "brz1.fetch");
        cycle(0, PH_DECODE, 16'h0405, "brz1.decode");
        cycle_n(0, PH_EXEC, 16'h0405, 1'b1, "brz1.exec");
        instr(16'hA202, "ldi");
        instr(16'h4805, "jsr");
        instr(16'h4080, "jsrr");

        // HALT held for 10 cycles, then released only by reset.
        instr(16'hF025, "halt");
        for (int k = 0; k < 10; k++) cycle(0, PH_HALT, 16'hF025, "halt.hold");
        cycle(1, PH_HALT, 16'hF025, "halt.rst");
        instr(16'h5042, "and_after_halt");

        // Reset landing in STR's second execute cycle.
        $display("instr str_rst ir=7283");
        cycle(0, PH_FETCH, 16'h0, "str_rst.fetch");
        cycle(0, PH_DECODE, 16'h7283, "str_rst.decode");
        cycle(0, PH_EXEC, 16'h7283, "str_rst.exec");
        cycle(1, PH_EXEC2, 16'h7283, "str_rst.exec2");
        instr(16'h3A01, "st_after_rst");

        // Random instruction stream (HALT excluded so the stream keeps going).
        for (int k = 0; k < 300; k++) begin
            ri = {4'($urandom_range(0, 14)), 12'($urandom)};
            instr(ri, $sformatf("rnd%0d", k));
        end

        // Final HALT, then wait for the monitor to drain.
        instr(16'hF000, "halt_end");
        cycle(0, PH_HALT, 16'hF000, "halt_end.hold");
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got=%0d pending want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
